// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the multi-player reaction timer.
// Holds the round FSM encoding, LED patterns and LCD handshake phases.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ANNOUNCE,
        DELAY,
        GO,
        REPORT
    } state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_REQ,
        HS_REL
    } hs_phase_t;

    localparam logic [7:0] LED_ON  = 8'hFF;
    localparam logic [7:0] LED_OFF = 8'h00;

    // Index width with a floor of one bit so a single player still gets a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reaction_timer_multi_winner_select.sv
// Combinational minimum finder over per-player times with a qualify mask.
// Strict less-than while scanning upward makes ties resolve to the lowest index.
module rt_winner_select
    import reaction_timer_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int TIME_W      = 10,
    parameter int IDX_W       = idx_width(NUM_PLAYERS)
) (
    input  logic [NUM_PLAYERS-1:0][TIME_W-1:0] times,
    input  logic [NUM_PLAYERS-1:0]             qualify,
    output logic [IDX_W-1:0]                   idx,
    output logic                               valid,
    output logic [TIME_W-1:0]                  min_time
);

    always_comb begin
        idx      = '0;
        valid    = 1'b0;
        min_time = '1;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (qualify[i] && (!valid || times[i] < min_time)) begin
                idx      = IDX_W'(i);
                valid    = 1'b1;
                min_time = times[i];
            end
        end
    end

endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer: shared random delay, per-player times and
// cheat/slow flags, round winner, session best, LCD 4-phase handshake.
module reaction_timer_multi
    import reaction_timer_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int TIME_W      = 10,
    parameter int RAND_W      = 13,
    parameter int SLOW_LIMIT  = 500,
    parameter int MIN_DELAY   = 100,
    parameter int TICK_DIV    = 1
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Start,
    input  logic [NUM_PLAYERS-1:0]        Btn,
    input  logic [RAND_W-1:0]             RandomValue,
    input  logic                          LCDAck,
    output logic [7:0]                    LED,
    output logic [NUM_PLAYERS*TIME_W-1:0] ReactionTime,
    output logic [NUM_PLAYERS-1:0]        Cheat,
    output logic [NUM_PLAYERS-1:0]        Slow,
    output logic                          Wait,
    output logic [idx_width(NUM_PLAYERS)-1:0] Winner,
    output logic                          WinnerValid,
    output logic [TIME_W-1:0]             BestTime,
    output logic                          LCDUpdate
);

    localparam int WIN_W = idx_width(NUM_PLAYERS);
    localparam int PRE_W = idx_width(TICK_DIV);

    state_t                            state_q, state_d;
    hs_phase_t                         phase_q, phase_d;
    logic                              start_prev_q, start_prev_d;
    logic [NUM_PLAYERS-1:0]            btn_prev_q, btn_prev_d;
    logic [PRE_W-1:0]                  tick_cnt_q, tick_cnt_d;
    logic [RAND_W-1:0]                 delay_q, delay_d;
    logic [RAND_W-1:0]                 delay_cnt_q, delay_cnt_d;
    logic [TIME_W-1:0]                 ms_cnt_q, ms_cnt_d;
    logic [NUM_PLAYERS-1:0]            answered_q, answered_d;
    logic                              report_first_q, report_first_d;
    logic [NUM_PLAYERS-1:0][TIME_W-1:0] rt_q, rt_d;
    logic [NUM_PLAYERS-1:0]            cheat_q, cheat_d;
    logic [NUM_PLAYERS-1:0]            slow_q, slow_d;
    logic [WIN_W-1:0]                  winner_q, winner_d;
    logic                              win_valid_q, win_valid_d;
    logic [TIME_W-1:0]                 best_q, best_d;
    logic [7:0]                        led_q, led_d;
    logic                              wait_q, wait_d;
    logic                              lcd_update_q, lcd_update_d;

    logic                   start_rise;
    logic [NUM_PLAYERS-1:0] btn_rise;
    logic [NUM_PLAYERS-1:0] press;
    logic                   tick;
    logic                   hs_done;
    logic [WIN_W-1:0]       sel_idx;
    logic                   sel_valid;
    logic [TIME_W-1:0]      sel_time;

    assign start_rise = Start & ~start_prev_q;
    assign btn_rise   = Btn & ~btn_prev_q;
    assign tick       = (tick_cnt_q == PRE_W'(TICK_DIV - 1));

    rt_winner_select #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .TIME_W      (TIME_W),
        .IDX_W       (WIN_W)
    ) u_winner_select (
        .times    (rt_q),
        .qualify  (~cheat_q & ~slow_q),
        .idx      (sel_idx),
        .valid    (sel_valid),
        .min_time (sel_time)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= IDLE;
            phase_q        <= HS_IDLE;
            start_prev_q   <= 1'b0;
            btn_prev_q     <= '0;
            tick_cnt_q     <= '0;
            delay_q        <= '0;
            delay_cnt_q    <= '0;
            ms_cnt_q       <= '0;
            answered_q     <= '0;
            report_first_q <= 1'b0;
            rt_q           <= '0;
            cheat_q        <= '0;
            slow_q         <= '0;
            winner_q       <= '0;
            win_valid_q    <= 1'b0;
            best_q         <= '1;
            led_q          <= LED_OFF;
            wait_q         <= 1'b0;
            lcd_update_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            start_prev_q   <= start_prev_d;
            btn_prev_q     <= btn_prev_d;
            tick_cnt_q     <= tick_cnt_d;
            delay_q        <= delay_d;
            delay_cnt_q    <= delay_cnt_d;
            ms_cnt_q       <= ms_cnt_d;
            answered_q     <= answered_d;
            report_first_q <= report_first_d;
            rt_q           <= rt_d;
            cheat_q        <= cheat_d;
            slow_q         <= slow_d;
            winner_q       <= winner_d;
            win_valid_q    <= win_valid_d;
            best_q         <= best_d;
            led_q          <= led_d;
            wait_q         <= wait_d;
            lcd_update_q   <= lcd_update_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        start_prev_d   = Start;
        btn_prev_d     = Btn;
        tick_cnt_d     = tick ? '0 : tick_cnt_q + PRE_W'(1);
        delay_d        = delay_q;
        delay_cnt_d    = delay_cnt_q;
        ms_cnt_d       = ms_cnt_q;
        answered_d     = answered_q;
        report_first_d = 1'b0;
        rt_d           = rt_q;
        cheat_d        = cheat_q;
        slow_d         = slow_q;
        winner_d       = winner_q;
        win_valid_d    = win_valid_q;
        best_d         = best_q;
        hs_done        = 1'b0;
        press          = btn_rise & ~cheat_q & ~answered_q;

        if (state_q == ANNOUNCE || state_q == REPORT) begin
            unique case (phase_q)
                HS_REQ:  if (LCDAck)  phase_d = HS_REL;
                HS_REL:  if (!LCDAck) hs_done = 1'b1;
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    delay_d     = (RandomValue < RAND_W'(MIN_DELAY)) ? RAND_W'(MIN_DELAY)
                                                                      : RandomValue;
                    rt_d        = '0;
                    cheat_d     = '0;
                    slow_d      = '0;
                    answered_d  = '0;
                    win_valid_d = 1'b0;
                    state_d     = ANNOUNCE;
                end
            end
            ANNOUNCE, DELAY: begin
                // Times were cleared at round start, so a cheat only needs its flag.
                cheat_d = cheat_q | btn_rise;
                if (state_q == ANNOUNCE) begin
                    if (hs_done) state_d = (&cheat_d) ? REPORT : DELAY;
                end else if (&cheat_d) begin
                    state_d = REPORT;
                end else if (tick) begin
                    if ({1'b0, delay_cnt_q} + (RAND_W+1)'(1) >= {1'b0, delay_q})
                        state_d = GO;
                    else
                        delay_cnt_d = delay_cnt_q + RAND_W'(1);
                end
            end
            GO: begin
                for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                    if (press[i]) begin
                        rt_d[i]       = ms_cnt_q;
                        answered_d[i] = 1'b1;
                    end
                end
                // A press landing on the limit cycle is already in answered_d.
                if (ms_cnt_q == TIME_W'(SLOW_LIMIT)) begin
                    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                        if (!answered_d[i] && !cheat_q[i]) begin
                            slow_d[i] = 1'b1;
                            rt_d[i]   = TIME_W'(SLOW_LIMIT);
                        end
                    end
                    state_d = REPORT;
                end else begin
                    if (&(answered_d | cheat_q)) state_d = REPORT;
                    if (tick) ms_cnt_d = ms_cnt_q + TIME_W'(1);
                end
            end
            REPORT: begin
                if (report_first_q) begin
                    winner_d    = sel_idx;
                    win_valid_d = sel_valid;
                    if (sel_valid && sel_time < best_q) best_d = sel_time;
                end
                if (hs_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            tick_cnt_d     = '0;
            delay_cnt_d    = '0;
            ms_cnt_d       = '0;
            phase_d        = (state_d == ANNOUNCE || state_d == REPORT) ? HS_REQ : HS_IDLE;
            report_first_d = (state_d == REPORT);
        end
    end

    always_comb begin
        led_d        = (state_d == GO) ? LED_ON : LED_OFF;
        wait_d       = (state_d == ANNOUNCE) || (state_d == DELAY);
        lcd_update_d = ((state_d == ANNOUNCE) || (state_d == REPORT)) && (phase_d == HS_REQ);
    end

    assign LED          = led_q;
    assign ReactionTime = rt_q;
    assign Cheat        = cheat_q;
    assign Slow         = slow_q;
    assign Wait         = wait_q;
    assign Winner       = winner_q;
    assign WinnerValid  = win_valid_q;
    assign BestTime     = best_q;
    assign LCDUpdate    = lcd_update_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench for reaction_timer_multi with two players at one tick per clock.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_reaction_timer_multi;
    import reaction_timer_pkg::*;

    localparam int NP = 2;
    localparam int TW = 10;
    localparam int RW = 13;
    localparam int SL = 500;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start;
    logic [NP-1:0] Btn;
    logic [RW-1:0] RandomValue;
    logic          LCDAck;
    logic [7:0]    LED;
    logic [NP*TW-1:0] ReactionTime;
    logic [NP-1:0] Cheat;
    logic [NP-1:0] Slow;
    logic          Wait;
    logic [0:0]    Winner;
    logic          WinnerValid;
    logic [TW-1:0] BestTime;
    logic          LCDUpdate;

    int checks = 0;
    int passes = 0;

    always #5 Clk = ~Clk;

    reaction_timer_multi #(
        .NUM_PLAYERS (NP),
        .TIME_W      (TW),
        .RAND_W      (RW),
        .SLOW_LIMIT  (SL),
        .MIN_DELAY   (100),
        .TICK_DIV    (1)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Start        (Start),
        .Btn          (Btn),
        .RandomValue  (RandomValue),
        .LCDAck       (LCDAck),
        .LED          (LED),
        .ReactionTime (ReactionTime),
        .Cheat        (Cheat),
        .Slow         (Slow),
        .Wait         (Wait),
        .Winner       (Winner),
        .WinnerValid  (WinnerValid),
        .BestTime     (BestTime),
        .LCDUpdate    (LCDUpdate)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_led"}, LED, LED_OFF);
        chk({tag, "_rt"}, ReactionTime, 0);
        chk({tag, "_cheat"}, Cheat, 0);
        chk({tag, "_slow"}, Slow, 0);
        chk({tag, "_wait"}, Wait, 0);
        chk({tag, "_winner"}, Winner, 0);
        chk({tag, "_wvalid"}, WinnerValid, 0);
        chk({tag, "_best"}, BestTime, 10'h3FF);
        chk({tag, "_lcd"}, LCDUpdate, 0);
        chk({tag, "_state"}, dut.state_q, IDLE);
    endtask

    task automatic start_round(input string tag, input int rv);
        RandomValue = RW'(rv);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk({tag, "_wait"}, Wait, 1);
    endtask

    // Responds to one LCD request; ack_dly cycles before raising the ack and
    // rel_dly cycles of holding it after the request drops.
    task automatic do_hs(input string tag, input int ack_dly, input int rel_dly,
                         input state_t st);
        int n = 0;
        while (LCDUpdate !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_req"}, LCDUpdate, 1);
        repeat (ack_dly) begin
            @(negedge Clk);
            chk({tag, "_hold"}, LCDUpdate, 1);
        end
        LCDAck = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (LCDUpdate !== 1'b0 && n < 50);
        chk({tag, "_drop"}, LCDUpdate, 0);
        repeat (rel_dly) begin
            @(negedge Clk);
            chk({tag, "_stay"}, dut.state_q, st);
            chk({tag, "_low"}, LCDUpdate, 0);
        end
        LCDAck = 1'b0;
    endtask

    task automatic delay_check(input string tag, input int d);
        repeat (d) @(negedge Clk);
        chk({tag, "_dly_led"}, LED, LED_OFF);
        chk({tag, "_dly_wait"}, Wait, 1);
        @(negedge Clk);
        chk({tag, "_go_led"}, LED, LED_ON);
        chk({tag, "_go_wait"}, Wait, 0);
    endtask

    // Called on the first GO cycle; pulses each button at its ms offset (-1 = never).
    task automatic run_go(input string tag, input int t0, input int t1);
        int k = 0;
        while (LED === LED_ON && k <= SL + 2) begin
            Btn[0] = (k == t0);
            Btn[1] = (k == t1);
            @(negedge Clk);
            k++;
        end
        Btn = '0;
        chk({tag, "_go_exit"}, LED, LED_OFF);
    endtask

    task automatic check_round(input string tag, input int rt0, input int rt1,
                               input logic [1:0] ch, input logic [1:0] sl,
                               input int win, input logic wv, input int best);
        chk({tag, "_rt0"}, ReactionTime[TW-1:0], rt0);
        chk({tag, "_rt1"}, ReactionTime[2*TW-1:TW], rt1);
        chk({tag, "_cheat"}, Cheat, ch);
        chk({tag, "_slow"}, Slow, sl);
        chk({tag, "_wvalid"}, WinnerValid, wv);
        if (wv) chk({tag, "_winner"}, Winner, win);
        chk({tag, "_best"}, BestTime, best);
        @(negedge Clk);
        chk({tag, "_idle"}, dut.state_q, IDLE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        Start = 1'b0;
        Btn = '0;
        LCDAck = 1'b0;
        RandomValue = '0;
        repeat (3) @(negedge Clk);
        reset_check("rst");
        Rst = 1'b0;
        @(negedge Clk);

        // 1: basic round, P0 faster
        start_round("t1", 150);
        do_hs("t1a", 0, 0, ANNOUNCE);
        delay_check("t1", 150);
        run_go("t1", 120, 200);
        do_hs("t1r", 0, 0, REPORT);
        check_round("t1", 120, 200, 2'b00, 2'b00, 0, 1'b1, 120);

        // 2: short random value clamps to 100, P1 cheats in DELAY
        start_round("t2", 20);
        do_hs("t2a", 0, 0, ANNOUNCE);
        repeat (80) @(negedge Clk);
        Btn = 2'b10;
        @(negedge Clk);
        Btn = '0;
        chk("t2_cheat_early", Cheat, 2'b10);
        repeat (19) @(negedge Clk);
        chk("t2_dly_led", LED, LED_OFF);
        @(negedge Clk);
        chk("t2_go_led", LED, LED_ON);
        run_go("t2", 150, 50);
        do_hs("t2r", 0, 0, REPORT);
        check_round("t2", 150, 0, 2'b10, 2'b00, 0, 1'b1, 120);

        // 3: both cheat, GO skipped
        start_round("t3", 150);
        do_hs("t3a", 0, 0, ANNOUNCE);
        repeat (40) @(negedge Clk);
        Btn = 2'b11;
        @(negedge Clk);
        Btn = '0;
        chk("t3_cheat", Cheat, 2'b11);
        chk("t3_state", dut.state_q, REPORT);
        chk("t3_led", LED, LED_OFF);
        do_hs("t3r", 0, 0, REPORT);
        chk("t3_led_after", LED, LED_OFF);
        check_round("t3", 0, 0, 2'b11, 2'b00, 0, 1'b0, 120);

        // 4: slow player, then new best, then press on the limit itself
        start_round("t4a", 150);
        do_hs("t4aa", 0, 0, ANNOUNCE);
        delay_check("t4a", 150);
        run_go("t4a", 300, -1);
        do_hs("t4ar", 0, 0, REPORT);
        check_round("t4a", 300, 500, 2'b00, 2'b10, 0, 1'b1, 120);

        start_round("t4b", 200);
        do_hs("t4ba", 0, 0, ANNOUNCE);
        delay_check("t4b", 200);
        run_go("t4b", 110, 90);
        do_hs("t4br", 0, 0, REPORT);
        check_round("t4b", 110, 90, 2'b00, 2'b00, 1, 1'b1, 90);

        start_round("t4c", 100);
        do_hs("t4ca", 0, 0, ANNOUNCE);
        delay_check("t4c", 100);
        run_go("t4c", 500, -1);
        do_hs("t4cr", 0, 0, REPORT);
        check_round("t4c", 500, 500, 2'b00, 2'b10, 0, 1'b1, 90);

        // 5: tie, slow LCD acknowledge
        start_round("t5", 120);
        do_hs("t5a", 0, 0, ANNOUNCE);
        delay_check("t5", 120);
        run_go("t5", 75, 75);
        do_hs("t5r", 5, 3, REPORT);
        check_round("t5", 75, 75, 2'b00, 2'b00, 0, 1'b1, 75);

        // 6: Start and LCDAck noise in GO, then reset mid-round
        start_round("t6", 100);
        do_hs("t6a", 0, 0, ANNOUNCE);
        delay_check("t6", 100);
        for (int k = 0; k < 30; k++) begin
            Btn[0] = (k == 20);
            LCDAck = k[0];
            Start = (k == 10);
            @(negedge Clk);
        end
        Btn = '0;
        Start = 1'b0;
        chk("t6_state_go", dut.state_q, GO);
        chk("t6_led", LED, LED_ON);
        chk("t6_wait", Wait, 0);
        chk("t6_lcd", LCDUpdate, 0);
        chk("t6_rt0", ReactionTime[TW-1:0], 20);
        LCDAck = 1'b1;
        Rst = 1'b1;
        @(negedge Clk);
        reset_check("t6_rst");
        Rst = 1'b0;
        LCDAck = 1'b0;
        @(negedge Clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
